// File: rtl/usb_uart_tx_fifo.sv
// rtl/usb_uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART transmitter
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   in_data     byte from upstream pipeline
//   in_valid    in_data valid
//   cts_n       active-low clear-to-send (only when USB_UART_TX_CTS_EN is defined)
//   in_ready    FIFO can accept a byte this cycle
//   tx          UART serial output, idle high
//   tx_busy     a frame is on the line
//   fifo_level  number of stored bytes, 0..FIFO_DEPTH
//
// Optional macro: USB_UART_TX_CTS_EN adds cts_n flow control at frame boundaries.
`timescale 1ns/1ps
module usb_uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 417,
  parameter int FIFO_DEPTH   = 16,
  localparam int FIFO_AW     = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
`ifdef USB_UART_TX_CTS_EN
  input  logic             cts_n,
`endif
  output logic             in_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]  FULL      = FIFO_DEPTH[FIFO_AW:0];

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [BAUD_W-1:0]  r_baud;
  logic               r_tx;

  logic w_push;
  logic w_pop;
  logic w_cts_ok;
  logic w_baud_done;

`ifdef USB_UART_TX_CTS_EN
  logic r_cts_meta;
  logic r_cts_sync;

  // Two-flop synchroniser; resets to "not clear" so nothing leaves until the far end allows it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = ~r_cts_sync;
`else
  assign w_cts_ok = 1'b1;
`endif

  // Ready depends only on the registered count, so a pop this cycle frees space next cycle.
  assign in_ready    = (r_count != FULL);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0) && w_cts_ok;
  assign w_baud_done = (r_baud == BAUD_LAST);

  assign tx         = r_tx;
  assign tx_busy    = (r_state != S_IDLE);
  assign fifo_level = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serialiser: tx is loaded on the edge that enters each state or bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_uart_tx_fifo.md
Name: usb_uart_tx_fifo

Overview:
- Downstream consumer of the USB OUT endpoint byte pipeline: accepts bytes on a valid/ready interface, buffers them in a small FIFO, and serialises them as 8N1 UART frames on a single TX pin.
- Decouples bursty USB packet delivery (up to 64 bytes back-to-back) from slow baud-rate drain.
- The endpoint stage stalls only when this FIFO is full.

Parameters:
- CLKS_PER_BIT, 417, clock cycles per UART bit (48 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 16, FIFO entries; power of two, 2..256.
- FIFO_AW, log2(FIFO_DEPTH), FIFO address width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- in_data  input  8  byte from upstream pipeline.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at rising clk.
- tx  output  1  UART serial output, idle high.
- tx_busy  output  1  high while a frame is on the line (state != IDLE).
- fifo_level  output  FIFO_AW+1  current number of stored bytes, 0..FIFO_DEPTH.

Behaviour:
Reset (reset==0 at a rising edge):
- tx=1, tx_busy=0, fifo_level=0, in_ready=1.
- Read pointer, write pointer, bit counter and baud counter all 0; state IDLE.
- Applied mid-frame, the frame is aborted and tx returns high on that edge. Buffered bytes are discarded.

FIFO:
- Circular RAM of FIFO_DEPTH x 8.
- Write and read pointers are FIFO_AW bits and wrap naturally.
- count is FIFO_AW+1 bits.
- in_ready = (count != FIFO_DEPTH), combinational from registered count only; it never depends on in_valid.
- Push on in_valid && in_ready. Pop only from IDLE when count != 0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with pop this cycle: in_ready still 0 this cycle and goes 1 the next.
- fifo_level = count.

Serialiser states:
- IDLE: tx=1. If count != 0, pop the head byte into shift register, baud counter=0, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0], LSB first. Every CLKS_PER_BIT cycles shift right and increment bit index. After bit index 7 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.

Timing and arithmetic:
- tx is registered, and the output changes on the edge entering each state or bit.
- Baud counter counts 0..CLKS_PER_BIT-1; its width is ceil(log2(CLKS_PER_BIT)) bits, minimum 1.
- Latency: byte pushed into an empty FIFO at edge N → IDLE pops at edge N+1 → tx falls at edge N+1 output.
- Frame = 10*CLKS_PER_BIT cycles. Back-to-back frames have exactly 1 IDLE cycle (tx high) between the stop bit and the next start bit.
- tx_busy is 1 in START, DATA and STOP.
- No data-dependent behaviour: bytes 0x00 and 0xFF are serialised identically in timing.

Optional Feature:
Macro: USB_UART_TX_CTS_EN.
- Defined:
  - Adds input port cts_n (1 bit, active-low clear-to-send from the remote end), double-flop synchronised inside the block; reset value of both flops is 1.
  - IDLE pops only when count != 0 and the synchronised cts_n == 0.
  - A frame already started always completes regardless of cts_n.
  - cts_n deassertion is honoured at the next IDLE, i.e. at a frame boundary.
- Not defined: no cts_n port; IDLE pops whenever count != 0.

Test Plan:
1. CLKS_PER_BIT=4. Reset, then push 0xA5 at edge N → tx falls at N+1. Line shows 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. tx_busy high for exactly 40 cycles.
2. CLKS_PER_BIT=4, FIFO_DEPTH=16. Hold in_valid high with 20 incrementing bytes 0x00..0x13 → in_ready drops when fifo_level=16 and rises one cycle after each pop. All 20 bytes appear on tx in order, with 41-cycle frame spacing.
3. Push on the same edge that IDLE pops with fifo_level=1 → fifo_level stays 1. Wrap-around is exercised by pushing more than FIFO_DEPTH bytes in total, and no byte is duplicated or lost.
4. Assert reset low during DATA bit 3 of 0x3C with 5 bytes queued → tx=1, fifo_level=0, tx_busy=0 on that edge. No further frames after release.
5. With USB_UART_TX_CTS_EN defined: cts_n=1 and push 0x55 → tx stays high. Drop cts_n → start bit within 3 cycles (2 sync flops plus pop). Raise cts_n mid-frame → frame completes and the next queued byte is held.
6. Boundary bytes 0x00 and 0xFF back-to-back, CLKS_PER_BIT=2 → exact 20-cycle frames. Stop bit high for 2 cycles, then a 1-cycle idle gap.
